// File: rtl/core_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : core_ctrl_if                                           |
// | Description : Host-side bundle for the core instruction sequencer:   |
// |               tile request/descriptor in, instruction word and       |
// |               status out.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface core_ctrl_if;
  logic        start;
  logic [10:0] w_base;
  logic [10:0] a_base;
  logic [10:0] p_base;
  logic [10:0] n_act;
  logic        acc_en;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  // Host / core side: issues tile requests, observes the sequencer
  modport master (
    output start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
    input  inst, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
    output inst, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/core_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : core_ctrl                                              |
// | Description : Tile sequencer. Drives the 34-bit core instruction     |
// |               word through kernel fetch, kernel load, activation     |
// |               fetch, execute and a ofifo_valid-paced psum drain.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module core_ctrl #(
  parameter int ROW = 8,
  parameter int COL = 8
) (
  input  logic        clk,
  input  logic        reset,
  core_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KRD  = 3'd1,
    S_KLD  = 3'd2,
    S_ARD  = 3'd3,
    S_EXE  = 3'd4,
    S_DRN  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // CEN/WEN of both memories high, everything else low
  localparam logic [33:0] c_idle_word = 34'h1_800C_0000;
  localparam logic [11:0] c_col       = 12'(COL);
  localparam logic [11:0] c_kld_last  = 12'(COL + ROW - 1);

  state_t      r_state;
  logic [11:0] r_cnt;
  logic [10:0] r_j;
  logic        r_drn;
  logic [10:0] r_w_base;
  logic [10:0] r_a_base;
  logic [10:0] r_p_base;
  logic [10:0] r_n_act;
  logic        r_acc;
  logic [33:0] r_inst;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  state_t      w_state_nxt;
  logic [11:0] w_cnt_nxt;
  logic [10:0] w_j_nxt;
  logic        w_latch;
  logic        w_issue;
  logic        w_err_nxt;
  logic [10:0] w_wb;
  logic [11:0] w_n_ext;
  logic [33:0] w_inst_nxt;

  // State, counters, latched descriptor and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 12'd0;
      r_j      <= 11'd0;
      r_drn    <= 1'b0;
      r_w_base <= 11'd0;
      r_a_base <= 11'd0;
      r_p_base <= 11'd0;
      r_n_act  <= 11'd0;
      r_acc    <= 1'b0;
      r_inst   <= c_idle_word;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_j     <= w_j_nxt;
      r_drn   <= w_issue;
      if (w_latch) begin
        r_w_base <= bus.w_base;
        r_a_base <= bus.a_base;
        r_p_base <= bus.p_base;
        r_n_act  <= bus.n_act;
        r_acc    <= bus.acc_en;
      end
      r_inst <= w_inst_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      r_err  <= w_err_nxt;
    end
  end

  // Next state/counters, then the instruction word for the coming cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 12'd1;
    w_j_nxt     = r_j;
    w_latch     = 1'b0;
    w_err_nxt   = 1'b0;
    w_issue     = 1'b0;
    w_n_ext     = {1'b0, r_n_act};
    w_inst_nxt  = c_idle_word;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 12'd0;
        if (bus.start) begin
          if (bus.n_act != 11'd0) begin
            w_latch     = 1'b1;
            w_j_nxt     = 11'd0;
            w_state_nxt = S_KRD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_KRD: begin
        if (r_cnt == c_col) begin
          w_state_nxt = S_KLD;
          w_cnt_nxt   = 12'd0;
        end
      end
      S_KLD: begin
        if (r_cnt == c_kld_last) begin
          w_state_nxt = S_ARD;
          w_cnt_nxt   = 12'd0;
        end
      end
      S_ARD: begin
        if (r_cnt == w_n_ext) begin
          w_state_nxt = S_EXE;
          w_cnt_nxt   = 12'd0;
        end
      end
      S_EXE: begin
        if (w_cnt_nxt == w_n_ext) begin
          w_state_nxt = S_DRN;
          w_cnt_nxt   = 12'd0;
          w_j_nxt     = 11'd0;
        end
      end
      S_DRN: begin
        if (r_j == r_n_act) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Pop only when valid was seen and the previous cycle was not a pop,
    // so ofifo_valid is always re-sampled after each read.
    w_issue = (w_state_nxt == S_DRN) && bus.ofifo_valid && !r_drn;
    if (w_issue) begin
      w_j_nxt = r_j + 11'd1;
    end

    // Base used on the very first KRD word comes straight from the inputs
    w_wb = w_latch ? bus.w_base : r_w_base;

    case (w_state_nxt)
      S_KRD: begin
        if (w_cnt_nxt < c_col) begin
          w_inst_nxt[19]   = 1'b0;
          w_inst_nxt[17:7] = w_wb + w_cnt_nxt[10:0];
        end
        if (w_cnt_nxt != 12'd0) begin
          w_inst_nxt[2] = 1'b1;
        end
      end
      S_KLD: begin
        if (w_cnt_nxt < c_col) begin
          w_inst_nxt[0] = 1'b1;
          w_inst_nxt[3] = 1'b1;
        end
      end
      S_ARD: begin
        if (w_cnt_nxt < w_n_ext) begin
          w_inst_nxt[19]   = 1'b0;
          w_inst_nxt[17:7] = r_a_base + w_cnt_nxt[10:0];
        end
        if (w_cnt_nxt != 12'd0) begin
          w_inst_nxt[2] = 1'b1;
        end
      end
      S_EXE: begin
        w_inst_nxt[1] = 1'b1;
        w_inst_nxt[3] = 1'b1;
      end
      S_DRN: begin
        if (w_issue) begin
          w_inst_nxt[33]    = r_acc;
          w_inst_nxt[32]    = 1'b0;
          w_inst_nxt[31]    = 1'b0;
          w_inst_nxt[30:20] = r_p_base + r_j;
          w_inst_nxt[6]     = 1'b1;
        end
      end
      default: begin
        w_inst_nxt = c_idle_word;
      end
    endcase
  end

  assign bus.inst = r_inst;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_core_ctrl                                           |
// | Description : Self-checking bench for core_ctrl: directed vector     |
// |               table, directed tiles and random tiles checked against |
// |               a phase-level reference model.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_core_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] c_idle = 34'h1_800C_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  core_ctrl_if bus ();

  core_ctrl #(.ROW(ROW), .COL(COL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [10:0] pmem_q[$];

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [10:0] w_base;
    logic [10:0] n_act;
    logic [33:0] exp_inst;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Instruction word assembled from its named fields
  function automatic logic [33:0] mk(input logic acc, input logic cenp, input logic wenp,
                                     input logic [10:0] ap, input logic cenx,
                                     input logic [10:0] ax, input logic ofrd,
                                     input logic l0rd, input logic l0wr,
                                     input logic exe, input logic ld);
    return {acc, cenp, wenp, ap, cenx, 1'b1, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
  endfunction

  // ofifo_valid pattern: 0 always high, 1 random, 2 low for the first 20 drain cycles
  function automatic logic pick(input int mode, input int dcyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return (dcyc >= 20);
  endfunction

  function automatic logic [63:0] obs();
    return {27'd0, bus.inst, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [63:0] expv(input logic [33:0] w, input logic b, input logic d);
    return {27'd0, w, b, d, 1'b0};
  endfunction

  task automatic run_tile(input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                          input logic [10:0] na, input logic acc, input int mode,
                          input int abort_at, output int busy_cycles);
    logic [33:0] exp_q[$];
    logic [10:0] ax;
    logic        v, v_prev, prev_iss, iss;
    int          j, dcyc;
    busy_cycles = 0;
    pmem_q.delete();
    for (int k = 0; k <= COL; k++) begin
      ax = wb + 11'(k);
      exp_q.push_back(mk(0, 1, 1, 0, (k >= COL), (k < COL) ? ax : 11'd0, 0, 0, (k >= 1), 0, 0));
    end
    for (int k = 0; k < COL + ROW; k++)
      exp_q.push_back((k < COL) ? mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1) : c_idle);
    for (int k = 0; k <= int'(na); k++) begin
      ax = ab + 11'(k);
      exp_q.push_back(mk(0, 1, 1, 0, (k >= int'(na)), (k < int'(na)) ? ax : 11'd0,
                         0, 0, (k >= 1), 0, 0));
    end
    for (int k = 0; k < int'(na); k++)
      exp_q.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0));

    bus.start = 1'b1; bus.w_base = wb; bus.a_base = ab; bus.p_base = pb;
    bus.n_act = na;   bus.acc_en = acc; bus.ofifo_valid = pick(mode, -1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.w_base = 11'($urandom); bus.a_base = 11'($urandom);
    bus.p_base = 11'($urandom); bus.n_act = 11'($urandom); bus.acc_en = ~acc;
    v_prev = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("pre_drain[%0d]", i), obs(), expv(exp_q[i], 1'b1, 1'b0));
      if (bus.busy) busy_cycles++;
      if (i == abort_at) begin
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_idle", obs(), expv(c_idle, 1'b0, 1'b0));
        return;
      end
      v = pick(mode, -1);
      bus.ofifo_valid = v;
      @(posedge clk); #1;
      v_prev = v;
    end
    j = 0; prev_iss = 1'b0; dcyc = 0;
    while (j < int'(na) && dcyc < 4000) begin
      iss = v_prev && !prev_iss;
      chk($sformatf("drain[%0d]", dcyc), obs(),
          expv(iss ? mk(acc, 0, 0, pb + 11'(j), 1, 0, 1, 0, 0, 0, 0) : c_idle, 1'b1, 1'b0));
      if (bus.busy) busy_cycles++;
      if (bus.inst[31] == 1'b0) pmem_q.push_back(bus.inst[30:20]);
      if (iss) j++;
      prev_iss = iss;
      v = pick(mode, dcyc);
      bus.ofifo_valid = v;
      @(posedge clk); #1;
      v_prev = v;
      dcyc++;
    end
    if (j < int'(na)) chk("drain_timeout", 64'(j), 64'(na));
    chk("done_cycle", obs(), expv(c_idle, 1'b1, 1'b1));
    if (bus.busy) busy_cycles++;
    @(posedge clk); #1;
    chk("back_idle", obs(), expv(c_idle, 1'b0, 1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int   bc;
    logic [10:0] wa;
    bus.start = 0; bus.w_base = 0; bus.a_base = 0; bus.p_base = 0;
    bus.n_act = 0; bus.acc_en = 0; bus.ofifo_valid = 0;

    vt[0] = '{1'b0, 1'b1, 11'd9,    11'd3, c_idle,           1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 11'd0,    11'd0, c_idle,           1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 11'd5,    11'd0, c_idle,           1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 11'd5,    11'd0, c_idle,           1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 11'd100,  11'd3, 34'h1_8004_3200,  1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 11'd7,    11'd0, 34'h1_8004_3284,  1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 11'd0,    11'd0, c_idle,           1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 11'd2047, 11'd1, 34'h1_8007_FF80,  1'b1, 1'b0};
    vt[8] = '{1'b0, 1'b0, 11'd0,    11'd0, c_idle,           1'b0, 1'b0};

    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      reset = vt[i].rst_n; bus.start = vt[i].start;
      bus.w_base = vt[i].w_base; bus.n_act = vt[i].n_act;
      @(posedge clk); #1;
      chk($sformatf("vec[%0d]", i), obs(),
          {27'd0, vt[i].exp_inst, vt[i].exp_busy, 1'b0, vt[i].exp_err});
    end
    reset = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;

    // Full tile with kernel phase from base 100, ofifo_valid held high
    run_tile(11'd100, 11'd200, 11'd50, 11'd4, 1'b1, 0, -1, bc);
    chk("tile_length", 64'(bc), 64'd42);
    chk("pmem_count", 64'(pmem_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < pmem_q.size(); i++)
      chk($sformatf("pmem_addr[%0d]", i), 64'(pmem_q[i]), 64'(50 + i));

    // PMEM address wrap
    run_tile(11'd3, 11'd2040, 11'd2046, 11'd4, 1'b0, 0, -1, bc);
    chk("wrap_count", 64'(pmem_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < pmem_q.size(); i++) begin
      wa = 11'd2046 + 11'(i);
      chk($sformatf("wrap_addr[%0d]", i), 64'(pmem_q[i]), 64'(wa));
    end

    // Stalled drain
    run_tile(11'd10, 11'd20, 11'd30, 11'd3, 1'b1, 2, -1, bc);

    // Mid-op reset during EXE, then a clean tile
    run_tile(11'd1, 11'd2, 11'd3, 11'd5, 1'b1, 0, (COL + 1) + (COL + ROW) + 6 + 2, bc);
    run_tile(11'd1, 11'd2, 11'd3, 11'd5, 1'b1, 0, -1, bc);

    // Minimum tile
    run_tile(11'd2047, 11'd2047, 11'd2047, 11'd1, 1'b0, 1, -1, bc);

    // Random tiles
    for (int t = 0; t < 6; t++)
      run_tile(11'($urandom), 11'($urandom), 11'($urandom),
               11'($urandom_range(1, 16)), 1'($urandom), 1, -1, bc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/core_ctrl.md
# core_ctrl

Instruction sequencer for the core. It drives the 34-bit `inst` bus to run one complete tile: kernel fetch, kernel load into the MAC array, activation fetch, execute, and psum drain from the OFIFO into PMEM. It sits above `core`, takes a start request plus a tile descriptor, and monitors `ofifo_valid` to pace the drain.

## Interface
- `row`, 8, PE rows in the MAC array; sets the kernel propagation wait.
- `col`, 8, PE columns; sets the number of kernel words per tile.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `reset` input 1: **synchronous, active-low**. Sampled 0 at a clock edge resets the block.
- `start` input 1: tile request; sampled only in IDLE.
- `w_base` input 11: XMEM base address of the `col` kernel words.
- `a_base` input 11: XMEM base address of the activation words.
- `p_base` input 11: PMEM base address for the psum rows.
- `n_act` input 11: number of activation words, and equally the number of psum rows, 1..2047.
- `acc_en` input 1: value driven on `inst[33]` during PMEM writes.
- `ofifo_valid` input 1: the OFIFO holds at least one row.
- `inst` output 34: registered instruction word to `core`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at tile completion.
- `err` output 1: one-cycle pulse when `start` is rejected.

## Operation
- **`inst` field map:**
  - [33] acc
  - [32] CEN_PMEM, [31] WEN_PMEM, [30:20] A_PMEM
  - [19] CEN_XMEM, [18] WEN_XMEM, [17:7] A_XMEM
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd
  - [3] l0_rd, [2] l0_wr, [1] execute, [0] load
  - CEN and WEN are active-low.
- **Idle word:** 34'h1_800C_0000. Both CENs and both WENs are 1; every other bit is 0. Any field not named in a state below holds its idle value.
- **Never driven:** `ififo_wr`, `ififo_rd`, and XMEM writes. XMEM is only ever read (WEN_XMEM stays 1).
- **States:** IDLE → KRD → KLD → ARD → EXE → DRN → DONE → IDLE.
- **IDLE:**
  - `start`=1 with `n_act`≠0: latch `w_base`, `a_base`, `p_base`, `n_act`, `acc_en`, then go to KRD.
  - `start`=1 with `n_act`=0: pulse `err`, stay in IDLE.
- **KRD (kernel fetch), `col`+1 cycles, counter k=0..col:**
  - For k<col: CEN_XMEM=0, A_XMEM=w_base+k.
  - For k≥1: l0_wr=1. This covers the one-cycle SRAM read latency.
- **KLD (kernel load), `col`+`row` cycles:**
  - First `col` cycles: load=1, l0_rd=1.
  - Remaining `row` cycles: idle word, so kernels finish propagating.
- **ARD (activation fetch), `n_act`+1 cycles:** same pattern as KRD, using `a_base` and `n_act`.
- **EXE, `n_act` cycles:** execute=1, l0_rd=1.
- **DRN (drain):** written counter j starts at 0.
  - Issue a drain word in a cycle when `ofifo_valid` was sampled 1 on the previous edge, no drain word was issued in the previous cycle, and j<n_act.
  - Drain word: ofifo_rd=1, CEN_PMEM=0, WEN_PMEM=0, A_PMEM=p_base+j, acc=acc_en. Then j increments.
  - Every other DRN cycle drives the idle word.
  - When j reaches n_act, go to DONE.
- **DONE, 1 cycle:** `done`=1, idle word, then IDLE.
- **Arithmetic:** all address sums are 11-bit and wrap modulo 2048, e.g. base 2046 + 3 = 1.
- **Ignored inputs:** `start` outside IDLE. Descriptor inputs change after latching.

## Timing
- **Registered outputs:** `inst`, `busy`, `done`, `err` are all registered. The value named for a state is the value present during that state's cycles.
- **Start latency:** `start` sampled at edge E puts the first KRD word on `inst` in the cycle after E. `busy` rises with it.
- **Total tile length:** (col+1) + (col+row) + (n_act+1) + n_act + drain + 1 cycles. Drain is at least 2·n_act−1 cycles.
- **Drain rate:** at most one drain word per 2 cycles. This guarantees `ofifo_valid` is re-sampled after each pop.
- **Reset:** `reset`=0 at any edge, including mid-tile, gives IDLE, the idle `inst` word, and `busy`=`done`=`err`=0 in the next cycle. All counters clear.
- **Reset priority:** reset wins over a simultaneous `start`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles → `inst`=34'h1_800C_0000, `busy`=0, `done`=0, `err`=0.
- **Kernel phase:** start with `w_base`=100, row=col=8 → 8 cycles with A_XMEM=100..107 and CEN_XMEM=0; l0_wr high for 8 cycles, offset by one cycle; then 8 cycles of load=1, followed by 8 idle cycles.
- **Full tile:** `a_base`=200, `p_base`=50, `n_act`=4, `acc_en`=1, `ofifo_valid` held 1 → exactly 4 PMEM writes to A_PMEM=50..53 with acc=1, spaced 2 cycles apart; `done` pulses once; total cycles = 9+16+5+4+7+1 = 42.
- **Stalled drain:** hold `ofifo_valid`=0 for 20 cycles in DRN → no ofifo_rd, `busy` stays 1; release → writes resume at the next j.
- **Wrap and reject:** `p_base`=2046 with `n_act`=4 → A_PMEM sequence 2046, 2047, 0, 1. Separately, `start` with `n_act`=0 → `err` pulses for 1 cycle, `busy` stays 0.
- **Mid-op reset:** `reset`=0 during EXE → the next cycle shows the idle word; a following `start` runs a clean full tile.
